fp_add_seq: RTL
===============

# fp_add_seq

Multi-cycle IEEE 754 single-precision adder. It is the addition counterpart to the team's combinational floating-point subtractor. Operands are captured on a start strobe and pass through a fixed four-stage state machine: align, add, normalize, round. The result is returned with a one-cycle done pulse. The block sits in the Practica 2 FP datapath, beside the subtractor, and feeds the same 32-bit result bus. A subtract operation is issued by the controller flipping B[31] before start.

## Interface
- No parameters. Format fixed at 1 sign, 8 exponent and 23 mantissa bits, bias 127.
- clk  in  1  single clock; everything updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request. Sampled only in IDLE; A and B are captured on that edge.
- A  in  32  operand A, IEEE 754 single.
- B  in  32  operand B, IEEE 754 single.
- S  out  32  registered result. Holds its value until the next result is written.
- done  out  1  one-cycle pulse, in the cycle S first shows the new result.
- busy  out  1  high in ALIGN, ADD, NORM and ROUND.
- ovf  out  1  overflow flag, registered with S and held with S.
- nv  out  1  invalid flag, registered with S and held with S.

## Operation
- States run IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE, one cycle each, with no stalls.
- Operand decode:
  - exponent 0: hidden bit 0, effective exponent 1 (subnormal);
  - otherwise: hidden bit 1.
- ALIGN:
  - swap the operands so the larger magnitude is first, comparing {exp, mant};
  - right-shift the smaller 24-bit significand by the exponent difference into a 27-bit field (significand, guard, round, sticky);
  - for a difference of 27 or more, the smaller field is all zero with sticky = (significand != 0);
  - sticky ORs every bit shifted out.
- ADD:
  - equal signs: add the fields, 28-bit sum including carry;
  - different signs: subtract the smaller field from the larger;
  - result sign is the sign of the larger-magnitude operand.
- NORM:
  - carry out: shift right 1 and increment the exponent; the sticky bit absorbs the lost LSB;
  - otherwise: left-shift by the leading-zero count, limited so the exponent never drops below 1;
  - if the limited result has no hidden bit, the biased exponent becomes 0 (gradual underflow, no flush to zero).
- ROUND:
  - round to nearest, ties to even: round up if G & (R | St | LSB);
  - a mantissa carry out of rounding increments the exponent;
  - a biased exponent of 255 or more gives ±infinity (0x7F800000 | sign) with ovf = 1.
- Special cases are decided in ALIGN from the captured operands, override the datapath and are written at the ROUND edge:
  - either operand NaN: S = 0x7FC00000, nv = 1;
  - +inf plus -inf: S = 0x7FC00000, nv = 1;
  - inf plus a finite value or same-sign inf: S = that inf, flags 0;
  - exact zero from cancellation: S = 0x00000000;
  - -0 plus -0: S = 0x80000000.
- ovf and nv are recomputed for every result, so a normal result clears them.

## Timing
- Reset (asynchronous, rst_n low):
  - state goes to IDLE;
  - S = 0x00000000, done = 0, busy = 0, ovf = 0, nv = 0.
- Fixed latency:
  - edge 0: start is high in IDLE and operands are captured;
  - edges 1, 2 and 3: ALIGN, ADD and NORM complete;
  - edge 4: the ROUND edge writes S and the flags, pulses done and returns the state to IDLE;
  - done is high during the cycle after edge 4.
- busy is high from after edge 0 until edge 4.
- start while busy is ignored; no queueing, and A and B are not resampled.
- start high in the done cycle, where the state is IDLE, is accepted. Back-to-back throughput is one result every 5 cycles.
- start held high continuously starts a new operation every 5 cycles.
- rst_n asserted mid-operation aborts it: no done, and S returns to 0.

## Test plan
- Basic add and latency:
  - start with A = 0x3F800000, B = 0x40000000 -> S = 0x40400000;
  - done high exactly in the cycle after the 4th edge following capture;
  - busy high for 4 cycles.
- Cancellation and signed zero:
  - 0x3F800000 + 0xBF800000 -> 0x00000000;
  - 0x80000000 + 0x80000000 -> 0x80000000.
- Round to nearest even:
  - 0x3F800000 + 0x33800000 -> 0x3F800000;
  - 0x3F800001 + 0x33800000 -> 0x3F800002.
- Overflow and specials:
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, ovf = 1;
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000, nv = 1;
  - 0x7FC00001 + 0x3F800000 -> 0x7FC00000, nv = 1;
  - next normal add clears both flags.
- Subnormals:
  - 0x00000001 + 0x00000001 -> 0x00000002;
  - 0x00800000 + 0x80000001 -> 0x007FFFFF.
- Handshake and reset:
  - start pulsed during busy with other operands -> ignored, first result unchanged, a single done;
  - rst_n pulsed low during NORM -> no done, S = 0, busy = 0;
  - next start completes normally.

Source files
------------

// File: rtl/fp_add_seq.sv
// IEEE 754 single-precision adder, sequential: IDLE -> ALIGN -> ADD -> NORM -> ROUND.
// Latency: 4 cycles from the start edge to the S update; done pulses one cycle after that edge.
// Backpressure: none; start is sampled only in IDLE, so a start while busy is dropped.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, operands A/B captured when high in IDLE
//   A, B        : IEEE 754 single operands
//   S           : registered result, held until the next result
//   done        : one-cycle pulse in the first cycle S shows a new result
//   busy        : high in ALIGN, ADD, NORM, ROUND
//   ovf, nv     : overflow / invalid flags, registered and held with S
module fp_add_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        done,
  output logic        busy,
  output logic        ovf,
  output logic        nv
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

  state_t state, state_nxt;

  // Captured operands
  logic [31:0] a_q, b_q;

  // Pipeline-like working registers, one set reused across the stages
  logic        sign_q;      // sign of the larger-magnitude operand
  logic        eff_sub_q;   // operand signs differ
  logic [9:0]  exp_q;       // working exponent, wide enough for +2 overflow
  logic [26:0] fl_q;        // larger field {sig, G, R, St}
  logic [26:0] fs_q;        // aligned smaller field
  logic [27:0] sum_q;       // add/sub result including carry
  logic [26:0] nf_q;        // normalized field
  logic        zero_q;      // exact zero result
  logic        spec_q;      // special-case result overrides the datapath
  logic [31:0] spec_res_q;
  logic        spec_nv_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // ALIGN: decode, swap, align, special-case detection
  // ---------------------------------------------------------------------------
  logic        a_ge_b;
  logic [31:0] op_l, op_s;
  logic [7:0]  exp_l_eff, exp_s_eff, exp_diff;
  logic [23:0] sig_l, sig_s;
  logic [53:0] shift_ext;
  logic [26:0] fs_aln;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        spec_d, spec_nv_d;
  logic [31:0] spec_res_d;

  always_comb begin
    a_ge_b    = (a_q[30:0] >= b_q[30:0]);
    op_l      = a_ge_b ? a_q : b_q;
    op_s      = a_ge_b ? b_q : a_q;
    // Subnormals use effective exponent 1 with hidden bit 0
    exp_l_eff = (op_l[30:23] == 8'd0) ? 8'd1 : op_l[30:23];
    exp_s_eff = (op_s[30:23] == 8'd0) ? 8'd1 : op_s[30:23];
    sig_l     = {(op_l[30:23] != 8'd0), op_l[22:0]};
    sig_s     = {(op_s[30:23] != 8'd0), op_s[22:0]};
    // Larger magnitude always has the larger or equal effective exponent
    exp_diff  = exp_l_eff - exp_s_eff;
    // Upper 27 bits are the shifted field, lower 27 bits are what fell off
    shift_ext = {sig_s, 30'd0} >> exp_diff;
    if (exp_diff >= 8'd27)
      fs_aln = {26'd0, (sig_s != 24'd0)};
    else
      fs_aln = {shift_ext[53:28], shift_ext[27] | (|shift_ext[26:0])};

    a_nan = (&a_q[30:23]) & (|a_q[22:0]);
    b_nan = (&b_q[30:23]) & (|b_q[22:0]);
    a_inf = (&a_q[30:23]) & ~(|a_q[22:0]);
    b_inf = (&b_q[30:23]) & ~(|b_q[22:0]);

    spec_d     = a_nan | b_nan | a_inf | b_inf;
    spec_nv_d  = 1'b0;
    spec_res_d = 32'h7FC00000;
    if (a_nan || b_nan || (a_inf && b_inf && (a_q[31] != b_q[31]))) begin
      spec_nv_d  = 1'b1;
      spec_res_d = 32'h7FC00000;
    end else if (a_inf) begin
      spec_res_d = a_q;
    end else if (b_inf) begin
      spec_res_d = b_q;
    end
  end

  // ---------------------------------------------------------------------------
  // NORM: carry handling or limited left shift
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    // Ascending scan: the highest set bit wins
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic [4:0]  lz, lshift;
  logic [9:0]  exp_m1;
  logic [26:0] shifted;
  logic [26:0] norm_f;
  logic [9:0]  norm_e;

  always_comb begin
    lz      = lzc27(sum_q[26:0]);
    exp_m1  = exp_q - 10'd1;
    // Never shift the exponent below 1; exp_m1 < 27 whenever it limits
    lshift  = ({5'd0, lz} < exp_m1) ? lz : exp_m1[4:0];
    shifted = sum_q[26:0] << lshift;
    if (sum_q[27]) begin
      norm_f = {sum_q[27:2], sum_q[1] | sum_q[0]};
      norm_e = exp_q + 10'd1;
    end else begin
      norm_f = shifted;
      // No hidden bit after the limited shift means a subnormal result
      norm_e = shifted[26] ? (exp_q - {5'd0, lshift}) : 10'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // ROUND: nearest-even, overflow, result assembly
  // ---------------------------------------------------------------------------
  logic [23:0] mant;
  logic        g_bit, r_bit, st_bit, rnd_up;
  logic [24:0] m25;
  logic [9:0]  exp_r;
  logic [22:0] frac;
  logic [31:0] res_s;
  logic        res_ovf, res_nv;

  always_comb begin
    mant   = nf_q[26:3];
    g_bit  = nf_q[2];
    r_bit  = nf_q[1];
    st_bit = nf_q[0];
    rnd_up = g_bit & (r_bit | st_bit | mant[0]);
    m25    = {1'b0, mant} + {24'd0, rnd_up};
    if (m25[24]) begin
      exp_r = exp_q + 10'd1;
      frac  = m25[23:1];
    end else begin
      // A subnormal rounding up into the hidden bit becomes the smallest normal
      exp_r = ((exp_q == 10'd0) && m25[23]) ? 10'd1 : exp_q;
      frac  = m25[22:0];
    end

    res_ovf = 1'b0;
    res_nv  = 1'b0;
    if (spec_q) begin
      res_s  = spec_res_q;
      res_nv = spec_nv_q;
    end else if (zero_q) begin
      // x + (-x) is +0; only -0 + -0 keeps the negative sign
      res_s = {sign_q & ~eff_sub_q, 31'd0};
    end else if (exp_r >= 10'd255) begin
      res_s   = {sign_q, 31'h7F800000};
      res_ovf = 1'b1;
    end else begin
      res_s = {sign_q, exp_r[7:0], frac};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      exp_q      <= 10'd0;
      fl_q       <= 27'd0;
      fs_q       <= 27'd0;
      sum_q      <= 28'd0;
      nf_q       <= 27'd0;
      zero_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'd0;
      spec_nv_q  <= 1'b0;
      S          <= 32'd0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      nv         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= A;
            b_q <= B;
          end
        end
        ALIGN: begin
          sign_q     <= op_l[31];
          eff_sub_q  <= op_l[31] ^ op_s[31];
          exp_q      <= {2'b00, exp_l_eff};
          fl_q       <= {sig_l, 3'b000};
          fs_q       <= fs_aln;
          spec_q     <= spec_d;
          spec_res_q <= spec_res_d;
          spec_nv_q  <= spec_nv_d;
        end
        ADD: begin
          if (eff_sub_q) sum_q <= {1'b0, fl_q} - {1'b0, fs_q};
          else           sum_q <= {1'b0, fl_q} + {1'b0, fs_q};
        end
        NORM: begin
          nf_q   <= norm_f;
          exp_q  <= norm_e;
          zero_q <= (sum_q == 28'd0);
        end
        ROUND: begin
          S    <= res_s;
          ovf  <= res_ovf;
          nv   <= res_nv;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
